// File: rtl/rgbw_pwm_engine.sv
// Four-channel phase-staggered PWM; duties are committed from a shadow only at the period wrap.
// Latency: outputs register 1 clk after cnt/active change; no backpressure, load is a fire-and-forget strobe.
module rgbw_pwm_engine #(
    parameter int WIDTH      = 8,
    parameter int PHASE_STEP = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_half,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty0,
    input  logic [WIDTH-1:0] duty1,
    input  logic [WIDTH-1:0] duty2,
    input  logic [WIDTH-1:0] duty3,
    input  logic             load,
    output logic             load_pending,
    output logic             load_ack,
    output logic             period_start,
    output logic             d0,
    output logic             d1,
    output logic             d2,
    output logic             d3
);
    localparam int               PERIOD   = (1 << WIDTH) - 1;
    localparam logic [WIDTH:0]   PERIOD_W = (WIDTH+1)'(PERIOD);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);

    function automatic logic [WIDTH:0] phase_off(input int k);
        return (WIDTH+1)'((k * PHASE_STEP) % PERIOD);
    endfunction

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_shadow [4];
    logic [WIDTH-1:0] r_active [4];
    logic             r_pending;
    logic             r_ack;
    logic             r_pstart;
    logic [3:0]       r_d;

    logic [WIDTH-1:0] w_duty [4];
    logic [WIDTH:0]   w_sum  [4];
    logic [WIDTH:0]   w_ph   [4];
    logic [3:0]       w_hit;
    logic             w_tick;
    logic             w_wrap;
    logic             w_commit;

    assign w_duty[0] = duty0;
    assign w_duty[1] = duty1;
    assign w_duty[2] = duty2;
    assign w_duty[3] = duty3;

    assign w_tick   = clk_half & enable;
    assign w_wrap   = w_tick & (r_cnt == CNT_LAST);
    // A disabled engine commits immediately so the first enabled period runs fresh duties.
    assign w_commit = r_pending & (w_wrap | ~enable);

    // Phase sum is one bit wider so the modulo fold never loses a carry.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_sum[k] = {1'b0, r_cnt} + phase_off(k);
            w_ph[k]  = (w_sum[k] >= PERIOD_W) ? (w_sum[k] - PERIOD_W) : w_sum[k];
            w_hit[k] = (w_ph[k] < {1'b0, r_active[k]});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
            r_pstart  <= 1'b0;
            r_d       <= '0;
            for (int k = 0; k < 4; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
        end else begin
            if (!enable) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= w_wrap ? '0 : r_cnt + WIDTH'(1);
            end

            r_pstart <= w_wrap;
            r_ack    <= w_commit;

            // A load coinciding with a commit keeps pending set: the old shadow is what commits.
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end

            for (int k = 0; k < 4; k++) begin
                if (w_commit) r_active[k] <= r_shadow[k];
                if (load)     r_shadow[k] <= w_duty[k];
            end

            r_d <= {4{enable}} & w_hit;
        end
    end

    assign load_pending = r_pending;
    assign load_ack     = r_ack;
    assign period_start = r_pstart;
    assign d0           = r_d[0];
    assign d1           = r_d[1];
    assign d2           = r_d[2];
    assign d3           = r_d[3];
endmodule

// File: tb/tb_rgbw_pwm_engine.sv
// Directed scenarios plus random traffic, checked every clk against a cycle reference model
// and per-period high-time counts.
module tb_rgbw_pwm_engine;
    localparam int PER = 255;

    logic       clk = 1'b0;
    logic       reset, clk_half, enable, load;
    logic [7:0] duty0, duty1, duty2, duty3;
    logic       load_pending, load_ack, period_start, d0, d1, d2, d3;

    always #5 clk = ~clk;

    rgbw_pwm_engine #(.WIDTH(8), .PHASE_STEP(64)) dut (
        .clk(clk), .reset(reset), .clk_half(clk_half), .enable(enable),
        .duty0(duty0), .duty1(duty1), .duty2(duty2), .duty3(duty3),
        .load(load), .load_pending(load_pending), .load_ack(load_ack),
        .period_start(period_start), .d0(d0), .d1(d1), .d2(d2), .d3(d3)
    );

    int    tests = 0;
    int    fails = 0;
    string tag   = "init";

    // Reference model state in plain integers
    int m_cnt;
    int m_sh  [4];
    int m_act [4];
    bit m_pend, m_ack, m_ps;
    bit m_d   [4];
    int off   [4];
    bit hp;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_step();
        bit tk, wr, cm;
        if (reset) begin
            m_cnt = 0; m_pend = 0; m_ack = 0; m_ps = 0;
            for (int k = 0; k < 4; k++) begin
                m_sh[k] = 0; m_act[k] = 0; m_d[k] = 0;
            end
            return;
        end
        for (int k = 0; k < 4; k++)
            m_d[k] = enable && (((m_cnt + off[k]) % PER) < m_act[k]);
        tk     = clk_half && enable;
        wr     = tk && (m_cnt == PER - 1);
        cm     = m_pend && (wr || !enable);
        m_ps   = wr;
        m_ack  = cm;
        if (cm) m_act = m_sh;
        if (load) begin
            m_sh[0] = duty0; m_sh[1] = duty1; m_sh[2] = duty2; m_sh[3] = duty3;
            m_pend  = 1;
        end else if (cm) begin
            m_pend = 0;
        end
        m_cnt = !enable ? 0 : (tk ? (m_cnt + 1) % PER : m_cnt);
    endtask

    task automatic cyc();
        logic [6:0] obs, exp;
        @(posedge clk);
        model_step();
        #1;
        obs = {load_pending, load_ack, period_start, d3, d2, d1, d0};
        exp = {m_pend, m_ack, m_ps, m_d[3], m_d[2], m_d[1], m_d[0]};
        chk(tag, {9'b0, obs}, {9'b0, exp});
    endtask

    task automatic cyc_half();
        clk_half = hp;
        hp       = !hp;
        cyc();
    endtask

    task automatic pulse_load(input int a, input int b, input int c, input int d);
        duty0 = 8'(a); duty1 = 8'(b); duty2 = 8'(c); duty3 = 8'(d);
        load  = 1'b1;
        cyc_half();
        load  = 1'b0;
    endtask

    task automatic wait_ps();
        int n = 0;
        do begin
            cyc_half();
            n++;
        end while (!period_start && n < 2000);
        chk({tag, "_ps_timeout"}, 16'(n < 2000), 16'd1);
    endtask

    task automatic run_to_cnt(input int c, input bit need_hp);
        int n = 0;
        while (!(m_cnt == c && (!need_hp || hp)) && n < 3000) begin
            cyc_half();
            n++;
        end
        chk({tag, "_cnt_timeout"}, 16'(n < 3000), 16'd1);
    endtask

    // Counts clks and per-channel high clks over one full period between period_start pulses.
    task automatic measure_period(input int e_clk, input int e0, input int e1, input int e2, input int e3);
        int nclk;
        int hi [4];
        wait_ps();
        nclk = 0;
        for (int k = 0; k < 4; k++) hi[k] = 0;
        do begin
            hi[0] += int'(d0); hi[1] += int'(d1); hi[2] += int'(d2); hi[3] += int'(d3);
            cyc_half();
            nclk++;
        end while (!period_start && nclk < 2000);
        chk({tag, "_period_len"}, 16'(nclk), 16'(e_clk));
        chk({tag, "_hi0"}, 16'(hi[0]), 16'(e0));
        chk({tag, "_hi1"}, 16'(hi[1]), 16'(e1));
        chk({tag, "_hi2"}, 16'(hi[2]), 16'(e2));
        chk({tag, "_hi3"}, 16'(hi[3]), 16'(e3));
    endtask

    initial begin
        for (int k = 0; k < 4; k++) off[k] = (k * 64) % PER;
        hp = 1'b0;
        reset = 1'b1; clk_half = 1'b0; enable = 1'b0; load = 1'b0;
        duty0 = 8'd0; duty1 = 8'd0; duty2 = 8'd0; duty3 = 8'd0;

        tag = "reset";
        cyc();
        chk("reset_outputs", {9'b0, load_pending, load_ack, period_start, d3, d2, d1, d0}, 16'd0);
        cyc();
        reset = 1'b0;

        // Half-rate tick, duty0=128: 256 high clks out of 510
        tag = "t1";
        pulse_load(128, 0, 0, 0);
        cyc_half();
        enable = 1'b1;
        measure_period(510, 256, 0, 0, 0);

        // Boundary duties
        tag = "t2";
        pulse_load(0, 255, 1, 254);
        wait_ps();
        measure_period(510, 0, 510, 2, 508);

        // Equal duties, staggered phases
        tag = "t4";
        pulse_load(64, 64, 64, 64);
        wait_ps();
        measure_period(510, 128, 128, 128, 128);

        // Mid-period double load: last one wins at the wrap
        tag = "t3";
        run_to_cnt(100, 1'b0);
        pulse_load(10, 64, 64, 64);
        chk("t3_pending_after_first", {15'b0, load_pending}, 16'd1);
        run_to_cnt(150, 1'b0);
        pulse_load(20, 64, 64, 64);
        wait_ps();
        chk("t3_ack_with_ps", {14'b0, load_ack, period_start}, 16'b11);
        chk("t3_pending_cleared", {15'b0, load_pending}, 16'd0);
        measure_period(510, 40, 128, 128, 128);

        // Load on the commit clk
        tag = "t5";
        pulse_load(30, 64, 64, 64);
        run_to_cnt(PER - 1, 1'b1);
        pulse_load(50, 64, 64, 64);
        chk("t5_ack", {15'b0, load_ack}, 16'd1);
        chk("t5_pending_kept", {15'b0, load_pending}, 16'd1);
        wait_ps();
        measure_period(510, 100, 128, 128, 128);

        // Enable drop with load pending, then reset mid-run with a load
        tag = "t6";
        pulse_load(77, 64, 64, 64);
        run_to_cnt(200, 1'b0);
        enable = 1'b0;
        cyc_half();
        chk("t6_drop_ack", {15'b0, load_ack}, 16'd1);
        chk("t6_drop_outputs", {11'b0, period_start, d3, d2, d1, d0}, 16'd0);
        cyc_half();
        chk("t6_drop_pending", {15'b0, load_pending}, 16'd0);
        enable = 1'b1;
        for (int i = 0; i < 40; i++) cyc_half();
        reset = 1'b1;
        pulse_load(99, 99, 99, 99);
        reset = 1'b0;
        chk("t6_reset_outputs", {9'b0, load_pending, load_ack, period_start, d3, d2, d1, d0}, 16'd0);
        cyc_half();
        chk("t6_reset_load_discarded", {15'b0, load_pending}, 16'd0);

        // Random traffic against the model
        tag = "rand";
        for (int i = 0; i < 5000; i++) begin
            clk_half = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 15) == 0);
            duty0    = 8'($urandom); duty1 = 8'($urandom);
            duty2    = 8'($urandom); duty3 = 8'($urandom);
            if (enable ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 9) == 0))
                enable = !enable;
            reset    = ($urandom_range(0, 999) == 0);
            cyc();
        end
        reset = 1'b0; load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
